entrada_salida: RTL

- Memory-mapped I/O (E/S) unit for the single-cycle processor datapath.
- Responds to the data-memory address window with address bit 7 set; the datapath passes it the low 7 address bits.
- Its read data feeds the datapath's memory/E-S result multiplexer, alongside data memory.
- Provides four output registers, four synchronised input ports and an optional 8-bit down-counting timer with an expiry flag and interrupt line.

---
 rtl/entrada_salida.sv | 125 ++++++++++++
 1 files changed

// File: rtl/entrada_salida.sv
// rtl/entrada_salida.sv - memory-mapped E/S unit: output registers, synchronised inputs, optional timer
// Define ES_TIMER_EN to build the down-counting timer, its control/status register and irq.
module entrada_salida (
   input  logic       clk,
   input  logic       reset,
   input  logic       activar,
   input  logic       escribir,
   input  logic [6:0] direccion,
   input  logic [7:0] dato_in,
   output logic [7:0] dato_out,
   input  logic [7:0] entrada0,
   input  logic [7:0] entrada1,
   input  logic [7:0] entrada2,
   input  logic [7:0] entrada3,
   output logic [7:0] salida0,
   output logic [7:0] salida1,
   output logic [7:0] salida2,
   output logic [7:0] salida3,
   output logic       irq
);

   logic             wr;
   logic             rd;
   logic [3:0][7:0]  ent;
   logic [3:0][7:0]  sync1;
   logic [3:0][7:0]  sync2;
   logic [3:0][7:0]  sal;

   assign wr  = activar & escribir;
   assign rd  = activar & ~escribir;
   assign ent = {entrada3, entrada2, entrada1, entrada0};

   assign salida0 = sal[0];
   assign salida1 = sal[1];
   assign salida2 = sal[2];
   assign salida3 = sal[3];

   // Two-flop synchroniser per input port; only the second stage is ever read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= ent;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sal <= '0;
      end else if (wr && direccion[6:2] == 5'd0) begin
         sal[direccion[1:0]] <= dato_in;
      end
   end

`ifdef ES_TIMER_EN
   logic [7:0] recarga;
   logic [7:0] cuenta;
   logic       en;
   logic       modo_auto;
   logic       exp_r;
   logic       expira;
   logic       wr_rec;
   logic       wr_ctl;

   assign expira = en && (cuenta == 8'd0);
   assign wr_rec = wr && (direccion == 7'h08);
   assign wr_ctl = wr && (direccion == 7'h0A);

   // CPU writes take priority over the timer for count and en; expiry beats an exp clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         recarga   <= 8'd0;
         cuenta    <= 8'd0;
         en        <= 1'b0;
         modo_auto <= 1'b0;
         exp_r     <= 1'b0;
      end else begin
         if (wr_rec) begin
            recarga <= dato_in;
            cuenta  <= dato_in;
         end else if (en) begin
            if (cuenta != 8'd0)
               cuenta <= cuenta - 8'd1;
            else if (modo_auto)
               cuenta <= recarga;
         end

         if (wr_ctl) begin
            en        <= dato_in[0];
            modo_auto <= dato_in[1];
         end else if (expira && !modo_auto) begin
            en <= 1'b0;
         end

         if (expira)
            exp_r <= 1'b1;
         else if (wr_ctl && dato_in[7])
            exp_r <= 1'b0;
      end
   end

   assign irq = exp_r;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      dato_out = 8'h00;
      if (rd) begin
         case (direccion)
            7'h00, 7'h01, 7'h02, 7'h03: dato_out = sal[direccion[1:0]];
            7'h04, 7'h05, 7'h06, 7'h07: dato_out = sync2[direccion[1:0]];
`ifdef ES_TIMER_EN
            7'h08: dato_out = recarga;
            7'h09: dato_out = cuenta;
            7'h0A: dato_out = {exp_r, 5'b00000, modo_auto, en};
`endif
            default: dato_out = 8'h00;
         endcase
      end
   end

endmodule
